control_escala: RTL and testbench

- Consumes the debounced button levels from the debounce stage (one instance per button) and turns them into a saturating scale-selection index, e.g. volts/div or time/div, for the oscilloscope display path.
- Each new press issues one step. Holding a button issues auto-repeat steps after an initial delay.
- Simultaneous up+down presses are rejected.
- Emits a one-cycle strobe whenever the index changes, so downstream display/acquisition logic reloads its settings.

---
 rtl/control_escala_pkg.sv | 22 ++
 rtl/control_escala_paso_saturado.sv | 40 ++++
 rtl/control_escala.sv | 154 +++++++++++++++
 tb/tb_control_escala.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/control_escala_pkg.sv
// Shared definitions for the scale-selection control: FSM encoding, step
// direction and the button timing budgets derived from the 100 MHz clock.
package control_escala_pkg;

    localparam int unsigned CLK_HZ            = 100_000_000;
    localparam int unsigned REPEAT_DELAY_DEF  = CLK_HZ / 2;   // 0.5 s hold before auto-repeat
    localparam int unsigned REPEAT_PERIOD_DEF = CLK_HZ / 10;  // 0.1 s between repeats
    localparam int unsigned DEBOUNCE_HOLD     = CLK_HZ / 20;  // 50 ms debounce stage upstream

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        REPEAT     = 2'd2,
        LOCK       = 2'd3
    } estado_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/control_escala_paso_saturado.sv
// Combinational step unit: applies one up/down step to the index and
// saturates at 0 / IDX_MAX, flagging either a change or a suppressed step.
module paso_saturado
    import control_escala_pkg::*;
#(
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned IDX_MAX = 7
) (
    input  logic [IDX_W-1:0] indice_i,
    input  logic             paso_i,
    input  logic             dir_i,
    output logic [IDX_W-1:0] indice_sig_c,
    output logic             cambio_c,
    output logic             limite_c
);

    always_comb begin
        indice_sig_c = indice_i;
        cambio_c     = 1'b0;
        limite_c     = 1'b0;
        if (paso_i) begin
            if (dir_i == DIR_UP) begin
                if (indice_i < IDX_W'(IDX_MAX)) begin
                    indice_sig_c = indice_i + IDX_W'(1);
                    cambio_c     = 1'b1;
                end else begin
                    limite_c = 1'b1;
                end
            end else begin
                if (indice_i != '0) begin
                    indice_sig_c = indice_i - IDX_W'(1);
                    cambio_c     = 1'b1;
                end else begin
                    limite_c = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/control_escala.sv
// Turns debounced up/down button levels into a saturating scale index with
// press-and-hold auto-repeat, rejecting simultaneous up+down presses.
module control_escala
    import control_escala_pkg::*;
#(
    parameter int unsigned IDX_W         = 3,
    parameter int unsigned IDX_MAX       = 7,
    parameter int unsigned IDX_RESET     = 3,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter int unsigned CNT_W         = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [IDX_W-1:0] indice,
    output logic             cambio,
    output logic             limite
);

    if (IDX_RESET > IDX_MAX || 64'(IDX_MAX) >= (64'd1 << IDX_W)) begin : g_bad_idx
        $error("control_escala: need IDX_RESET <= IDX_MAX < 2**IDX_W");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_timing
        $error("control_escala: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end
    if (64'(REPEAT_DELAY - 1) >= (64'd1 << CNT_W) ||
        64'(REPEAT_PERIOD - 1) >= (64'd1 << CNT_W)) begin : g_bad_cnt
        $error("control_escala: CNT_W too narrow for the repeat timer");
    end

    estado_t          state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0] indice_q, indice_d;
    logic             cambio_q, cambio_d;
    logic             limite_q, limite_d;

    logic             activo_c, opuesto_c, terminal_c;
    logic             paso_c;
    dir_t             paso_dir_c;

    // Button that owns the current hold, the other one, and timer expiry
    assign activo_c   = (dir_q == DIR_UP) ? btn_up   : btn_down;
    assign opuesto_c  = (dir_q == DIR_UP) ? btn_down : btn_up;
    assign terminal_c = (state_q == WAIT_DELAY) ? (timer_q == CNT_W'(REPEAT_DELAY - 1))
                                                : (timer_q == CNT_W'(REPEAT_PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (btn_up && !btn_down) begin
                    state_d = WAIT_DELAY;
                    dir_d   = DIR_UP;
                end else if (btn_down && !btn_up) begin
                    state_d = WAIT_DELAY;
                    dir_d   = DIR_DOWN;
                end else if (btn_up && btn_down) begin
                    state_d = LOCK;
                end
            end
            WAIT_DELAY, REPEAT: begin
                if (!activo_c) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (opuesto_c) begin
                    state_d = LOCK;
                    timer_d = '0;
                end else if (terminal_c) begin
                    state_d = REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            LOCK: begin
                timer_d = '0;
                if (!btn_up && !btn_down) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Step request: immediate on a clean press, then on each timer expiry
    always_comb begin
        paso_c     = 1'b0;
        paso_dir_c = dir_q;
        case (state_q)
            IDLE: begin
                if (btn_up ^ btn_down) begin
                    paso_c     = 1'b1;
                    paso_dir_c = btn_up ? DIR_UP : DIR_DOWN;
                end
            end
            WAIT_DELAY, REPEAT: begin
                paso_c = activo_c && !opuesto_c && terminal_c;
            end
            default: begin
                paso_c = 1'b0;
            end
        endcase
    end

    paso_saturado #(
        .IDX_W   (IDX_W),
        .IDX_MAX (IDX_MAX)
    ) u_paso (
        .indice_i     (indice_q),
        .paso_i       (paso_c),
        .dir_i        (paso_dir_c),
        .indice_sig_c (indice_d),
        .cambio_c     (cambio_d),
        .limite_c     (limite_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            indice_q <= IDX_W'(IDX_RESET);
            cambio_q <= 1'b0;
            limite_q <= 1'b0;
        end else begin
            indice_q <= indice_d;
            cambio_q <= cambio_d;
            limite_q <= limite_d;
        end
    end

    assign indice = indice_q;
    assign cambio = cambio_q;
    assign limite = limite_q;

endmodule

// File: tb/tb_control_escala.sv
// Directed bench for control_escala: a per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_control_escala;

    localparam int unsigned IDX_W         = 3;
    localparam int unsigned IDX_MAX       = 7;
    localparam int unsigned IDX_RESET     = 3;
    localparam int unsigned REPEAT_DELAY  = 8;
    localparam int unsigned REPEAT_PERIOD = 4;
    localparam int unsigned CNT_W         = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             btn_up;
    logic             btn_down;
    logic [IDX_W-1:0] indice;
    logic             cambio;
    logic             limite;

    int n_tests = 0;
    int n_fail  = 0;

    control_escala #(
        .IDX_W         (IDX_W),
        .IDX_MAX       (IDX_MAX),
        .IDX_RESET     (IDX_RESET),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .indice   (indice),
        .cambio   (cambio),
        .limite   (limite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             up;
        logic             down;
        logic [IDX_W-1:0] idx;
        logic             c;
        logic             l;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic u, input logic d, input int idx, input logic c, input logic l);
        vec_t v;
        v.up   = u;
        v.down = d;
        v.idx  = IDX_W'(idx);
        v.c    = c;
        v.l    = l;
        vecs.push_back(v);
    endtask

    // n cycles with the given buttons and no step expected
    task automatic hold(input int n, input logic u, input logic d, input int idx);
        for (int i = 0; i < n; i++) add(u, d, idx, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int ei, input logic ec, input logic el);
        n_tests++;
        if (indice !== IDX_W'(ei) || cambio !== ec || limite !== el) begin
            n_fail++;
            $display("FAIL %s: got indice=%0d cambio=%b limite=%b, expected indice=%0d cambio=%b limite=%b",
                     name, indice, cambio, limite, ei, ec, el);
        end
    endtask

    task automatic tick(input logic u, input logic d);
        btn_up   = u;
        btn_down = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        #12;
        check("reset_state", 3, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Single press held 3 cycles: one step 3->4
        add(1, 0, 4, 1, 0);
        hold(2, 1, 0, 4);
        hold(2, 0, 0, 4);
        // Back to 3
        add(0, 1, 3, 1, 0);
        hold(2, 0, 0, 3);
        // Hold up from 3: immediate, +8, then every 4, saturate with limite
        add(1, 0, 4, 1, 0);
        hold(7, 1, 0, 4);
        add(1, 0, 5, 1, 0);
        hold(3, 1, 0, 5);
        add(1, 0, 6, 1, 0);
        hold(3, 1, 0, 6);
        add(1, 0, 7, 1, 0);
        hold(3, 1, 0, 7);
        add(1, 0, 7, 0, 1);
        hold(3, 1, 0, 7);
        add(1, 0, 7, 0, 1);
        hold(2, 0, 0, 7);
        // Walk down to 1 with separate presses
        for (int k = 6; k >= 1; k--) begin
            add(0, 1, k, 1, 0);
            hold(1, 0, 0, k);
        end
        // Hold down from 1: step to 0, then limite, never wraps
        add(0, 1, 0, 1, 0);
        hold(7, 0, 1, 0);
        add(0, 1, 0, 0, 1);
        hold(3, 0, 1, 0);
        add(0, 1, 0, 0, 1);
        hold(2, 0, 0, 0);
        // Simultaneous press -> LOCK; releasing only up keeps LOCK
        add(1, 0, 1, 1, 0);
        hold(1, 0, 0, 1);
        hold(2, 1, 1, 1);
        hold(2, 0, 1, 1);
        hold(1, 0, 0, 1);
        add(0, 1, 0, 1, 0);
        hold(1, 0, 0, 0);
        // Down during an up hold -> LOCK, no more steps
        add(1, 0, 1, 1, 0);
        hold(3, 1, 0, 1);
        hold(12, 1, 1, 1);
        hold(1, 0, 0, 1);
        // One-cycle release: two immediate steps, repeat timer restarts
        add(1, 0, 2, 1, 0);
        hold(2, 1, 0, 2);
        hold(1, 0, 0, 2);
        add(1, 0, 3, 1, 0);
        hold(7, 1, 0, 3);
        add(1, 0, 4, 1, 0);
        hold(3, 1, 0, 4);
        hold(1, 0, 0, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].up, vecs[i].down);
            check($sformatf("vec%0d", i), int'(vecs[i].idx), vecs[i].c, vecs[i].l);
        end

        // Reach REPEAT at indice 6, then reset asynchronously while holding up
        tick(1, 0);
        check("mid_press", 5, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick(1, 0);
            check($sformatf("mid_wait%0d", i), 5, 1'b0, 1'b0);
        end
        tick(1, 0);
        check("mid_repeat_step", 6, 1'b1, 1'b0);
        tick(1, 0);
        check("mid_repeat_hold", 6, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 3, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("fresh_press_after_reset", 4, 1'b1, 1'b0);
        tick(1, 0);
        check("pulse_one_cycle", 4, 1'b0, 1'b0);
        tick(0, 0);
        check("release_after_reset", 4, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
